// File: rtl/mp_add_pkg.sv
// mp_add_pkg: shared types and helpers for the multi-precision add/subtract sequencer.
package mp_add_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    typedef struct packed {
        logic carry;
        logic overflow;
        logic parity;
        logic zero;
        logic sign;
    } flags_t;

    function automatic int idx_w(input int words);
        return (words > 1) ? $clog2(words) : 1;
    endfunction

endpackage

// File: rtl/mp_add_seq_if.sv
// mp_add_seq_if: operand/result handshake bundle for mp_add_seq.
interface mp_add_seq_if #(
    parameter int N     = 4,
    parameter int WORDS = 2
);
    logic                 in_valid;
    logic                 in_ready;
    logic                 op_sub;
    logic [N*WORDS-1:0]   num1;
    logic [N*WORDS-1:0]   num2;
    logic                 out_valid;
    logic                 out_ready;
    logic [N*WORDS-1:0]   sum;
    logic                 carry_flag;
    logic                 overflow_flag;
    logic                 parity_flag;
    logic                 zero_flag;
    logic                 sign_flag;

    modport master (
        output in_valid, op_sub, num1, num2, out_ready,
        input  in_ready, out_valid, sum, carry_flag, overflow_flag, parity_flag, zero_flag, sign_flag
    );

    modport slave (
        input  in_valid, op_sub, num1, num2, out_ready,
        output in_ready, out_valid, sum, carry_flag, overflow_flag, parity_flag, zero_flag, sign_flag
    );
endinterface

// File: rtl/mp_add_seq_add_slice.sv
// add_slice: N-bit combinational adder slice with overflow, parity and zero outputs.
module add_slice #(
    parameter int N = 4
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    output logic [N-1:0] s,
    output logic         cout,
    output logic         ovf,
    output logic         par,
    output logic         zero
);
    assign {cout, s} = {1'b0, a} + {1'b0, b} + {{N{1'b0}}, cin};
    assign ovf       = (a[N-1] & b[N-1] & ~s[N-1]) | (~a[N-1] & ~b[N-1] & s[N-1]);
    assign par       = ~^s;
    assign zero      = ~|s;
endmodule

// File: rtl/mp_add_seq.sv
// mp_add_seq: W-bit add/subtract run N bits per cycle through one shared adder slice, LS word first.
module mp_add_seq
    import mp_add_pkg::*;
#(
    parameter int N     = 4,
    parameter int WORDS = 2
) (
    input logic         clk,
    input logic         rst,
    mp_add_seq_if.slave bus
);
    localparam int W  = N * WORDS;
    localparam int IW = idx_w(WORDS);
    // Slice parities are "even" bits, so the seed absorbs the odd-word-count inversion.
    localparam logic PAR_SEED = 1'(WORDS % 2 == 0);

    state_t         state_q, state_d;
    logic [IW-1:0]  idx_q, idx_d;
    logic           carry_q, carry_d;
    logic           zacc_q, zacc_d;
    logic           pacc_q, pacc_d;
    logic [W-1:0]   a_q, a_d;
    logic [W-1:0]   b_q, b_d;
    logic [W-1:0]   sum_q, sum_d;
    flags_t         flags_q, flags_d;

    logic [N-1:0]   sl_a, sl_b, sl_s;
    logic           sl_cout, sl_ovf, sl_par, sl_zero;
    logic           last;

    assign sl_a = a_q[int'(idx_q)*N +: N];
    assign sl_b = b_q[int'(idx_q)*N +: N];
    assign last = (idx_q == IW'(WORDS - 1));

    add_slice #(.N(N)) u_slice (
        .a    (sl_a),
        .b    (sl_b),
        .cin  (carry_q),
        .s    (sl_s),
        .cout (sl_cout),
        .ovf  (sl_ovf),
        .par  (sl_par),
        .zero (sl_zero)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        zacc_d  = zacc_q;
        pacc_d  = pacc_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        flags_d = flags_q;
        case (state_q)
            IDLE: if (bus.in_valid) begin
                a_d     = bus.num1;
                b_d     = bus.op_sub ? ~bus.num2 : bus.num2;
                carry_d = bus.op_sub;
                idx_d   = '0;
                zacc_d  = 1'b1;
                pacc_d  = PAR_SEED;
                state_d = RUN;
            end
            RUN: begin
                sum_d[int'(idx_q)*N +: N] = sl_s;
                carry_d = sl_cout;
                zacc_d  = zacc_q & sl_zero;
                pacc_d  = pacc_q ^ sl_par;
                if (last) begin
                    flags_d = '{carry: sl_cout, overflow: sl_ovf, parity: pacc_q ^ sl_par,
                                zero: zacc_q & sl_zero, sign: sl_s[N-1]};
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + IW'(1);
                end
            end
            DONE: state_d = bus.out_ready ? IDLE : DONE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            carry_q <= 1'b0;
            zacc_q  <= 1'b0;
            pacc_q  <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            flags_q <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            zacc_q  <= zacc_d;
            pacc_q  <= pacc_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            flags_q <= flags_d;
        end
    end

    assign bus.in_ready      = (state_q == IDLE);
    assign bus.out_valid     = (state_q == DONE);
    assign bus.sum           = sum_q;
    assign bus.carry_flag    = flags_q.carry;
    assign bus.overflow_flag = flags_q.overflow;
    assign bus.parity_flag   = flags_q.parity;
    assign bus.zero_flag     = flags_q.zero;
    assign bus.sign_flag     = flags_q.sign;
endmodule

// File: doc/mp_add_seq.md
Name: mp_add_seq

Overview:
- Multi-precision add/subtract sequencer.
- Accepts two W = N*WORDS bit operands and processes them N bits per cycle on a single shared N-bit adder slice, least significant word first, chaining carry between words.
- Produces the full result and ALU flags: carry, overflow, parity, zero, sign.
- Sits between the register/operand bus and the flag-producing adder datapath. Allows wide arithmetic without a wide carry chain.

Parameters:
- N, 4, adder slice width in bits (>=2).
- WORDS, 2, number of slices per operation (>=1). W = N*WORDS.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  synchronous active-high reset.
- in_valid  in  1  operands and op are valid.
- in_ready  out  1  block can accept an operation.
- op_sub  in  1  0 = num1+num2; 1 = num1-num2.
- num1  in  W  operand A.
- num2  in  W  operand B.
- out_valid  out  1  result and flags are valid.
- out_ready  in  1  consumer accepts the result.
- sum  out  W  result, modulo 2^W.
- carry_flag  out  1  carry-out of the top slice. For subtract, 1 = no borrow.
- overflow_flag  out  1  signed overflow of the full W-bit operation.
- parity_flag  out  1  1 when sum has an even number of ones.
- zero_flag  out  1  1 when sum == 0.
- sign_flag  out  1  sum[W-1].

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high. Ports are named clk and rst.
- Reset values: state=IDLE, in_ready=1, out_valid=0, sum=0, all flags=0, slice index=0, carry register=0.
- States:
  - IDLE: in_ready=1. On in_valid&in_ready, latch num1, op_sub, and num2 (inverted if op_sub). Carry register <= op_sub. Index <= 0. Go to RUN.
  - RUN: in_ready=0. Each cycle, slice i of the latched operands plus the carry register goes through the adder slice. Result word i is written into sum. Carry register <= slice carry-out. The zero accumulator ANDs in the slice zero result; the parity accumulator XORs in the slice parity. On i == WORDS-1, capture carry_flag and overflow_flag from that slice, then go to DONE. Otherwise i <= i+1.
  - DONE: out_valid=1. sum and flags are held stable while out_ready=0. On out_ready, go to IDLE. out_valid=0 and in_ready=1 on the next cycle.
- Latency: acceptance edge at cycle k. The RUN slices occupy edges k+1..k+WORDS. out_valid is high starting in the cycle after edge k+WORDS, so the minimum initiation interval is WORDS+2 cycles.
- Overflow: top-slice rule. A' = latched num1 MSB, B' = effective (possibly inverted) num2 MSB, S = sum[W-1]. overflow = (A'&B'&~S) | (~A'&~B'&S).
- Operand capture: inputs are sampled only at acceptance. Changes to num1, num2 or op_sub afterwards have no effect.
- Sum visibility: sum may update word-by-word during RUN. It is only meaningful while out_valid=1.
- WORDS=1: RUN lasts exactly one cycle.
- in_valid while busy is ignored (in_ready=0). It does not queue.
- rst asserted in any state: next cycle matches the reset values and any in-flight operation is discarded.
- out_ready asserted while not in DONE has no effect.

Decomposition:
- Package mp_add_pkg:
  - state enum {IDLE, RUN, DONE}.
  - flags struct {carry, overflow, parity, zero, sign}.
  - localparam for index width = clog2(WORDS), minimum 1.
- Sub-module add_slice: N-bit combinational adder.
  - Inputs: a, b, cin.
  - Outputs: s, cout, ovf (MSB rule above), par (~^s), zero (~|s).
  - Instantiated once; the sequencer owns all state.

Test Plan (N=4, WORDS=2, W=8):
- Add 0x7F+0x01 -> sum=0x80, carry=0, overflow=1, sign=1, zero=0, parity=0. out_valid rises 2 edges after acceptance.
- Add 0xFF+0x01 -> sum=0x00, carry=1, overflow=0, zero=1, parity=1, sign=0. Checks the inter-slice carry chain.
- Sub 0x00-0x01 -> sum=0xFF, carry=0 (borrow), sign=1, parity=1, overflow=0. Sub 0x80-0x01 -> sum=0x7F, carry=1, overflow=1, parity=0.
- Backpressure: complete 0x05-0x05 (sum=0x00, carry=1, zero=1) with out_ready=0 for 5 cycles. Outputs stay stable, in_ready=0, and a second in_valid is not accepted. Release out_ready, then accept the next op one cycle later.
- Change num1/num2 during RUN -> the result reflects the captured values only.
- Assert rst during RUN -> next cycle in_ready=1, out_valid=0, flags=0. A following 0x12+0x34 -> sum=0x46, carry=0, parity=0, zero=0.
